moore_seq_gen: RTL and testbench
================================

// Module: moore_seq_gen
// PURPOSE
//   Serial pattern transmitter. It drives the bit stream that the Moore sequence detectors
//   (e.g. the 101 detector) consume.
//   - Latches a PAT_W-bit pattern and a repeat count on start.
//   - Shifts the pattern out MSB first, one bit per clk, for the requested number of repeats.
//   - Can insert an optional one-cycle idle gap between repeats.
//   - Sits upstream of a detector: data_out feeds the detector's data_in directly.
// PARAMETERS
//   PAT_W  3  pattern length in bits (>=2)
//   CNT_W  4  width of repeat count; max repeats = 2**CNT_W-1
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-low reset
//   start     in   1      request; sampled only in IDLE
//   pattern   in   PAT_W  pattern to send, latched on accepted start
//   repeat_n  in   CNT_W  number of pattern repeats, latched on accepted start
//   gap_en    in   1      1 = insert one idle cycle between repeats, latched on accepted start
//   data_out  out  1      serial bit (registered)
//   valid_out out  1      1 while data_out carries a pattern bit
//   busy      out  1      1 in any state other than IDLE
//   done      out  1      one-cycle pulse in DONE
// BEHAVIOUR
//   - All outputs are registered Moore outputs; no combinational path from inputs to outputs.
//   - Reset (rst=0, async): state=IDLE; data_out=0, valid_out=0, busy=0, done=0.
//     Internal shift register, bit counter and repeat counter are cleared.
//     Reset mid-stream aborts immediately with no done pulse.
//   - States: IDLE, SHIFT, GAP, DONE.
//   - IDLE
//     - start=1 at edge k latches pattern, repeat_n and gap_en.
//     - repeat_n!=0: SHIFT at edge k. data_out=pattern[PAT_W-1] and valid_out=1 are visible after edge k.
//     - repeat_n==0: DONE at edge k. No bits are sent.
//   - SHIFT
//     - Each edge advances one bit, MSB to LSB. The bit counter runs 0..PAT_W-1.
//     - After the LSB cycle, decrement the repeat counter.
//       - remaining>0 and gap_en=1: GAP.
//       - remaining>0 and gap_en=0: reload pattern; the MSB follows the LSB with no bubble.
//       - remaining==0: DONE.
//   - GAP: exactly one cycle, data_out=0 and valid_out=0, then SHIFT with the pattern reloaded.
//   - DONE: done=1, busy=1, valid_out=0, data_out=0 for one cycle, then IDLE. busy drops the cycle after done.
//   - Throughput and latency:
//     - Total valid cycles = PAT_W*repeat_n.
//     - Stream length = PAT_W*repeat_n + (repeat_n-1)*gap_en cycles.
//   - Start handling:
//     - start is ignored outside IDLE.
//     - Latched values are stable for the whole transfer; input changes mid-stream have no effect.
//     - start held high continuously begins a new transfer on the first IDLE cycle after DONE.
//   - Width rules:
//     - The repeat counter is CNT_W bits and never underflows; the 0 case goes straight to DONE.
//     - The bit counter is $clog2(PAT_W) bits.
// TESTING
//   1. Reset, then pattern=3'b101, repeat_n=2, gap_en=0
//      -> data_out 1,0,1,1,0,1 with valid_out=1 for 6 cycles; done pulses on cycle 7; busy=0 on cycle 8.
//   2. Same transfer with gap_en=1
//      -> 1,0,1, gap (valid_out=0, data_out=0), 1,0,1; done on cycle 8.
//   3. repeat_n=0, start pulse
//      -> valid_out never asserts; done=1 the cycle after start; busy high for exactly 1 cycle.
//   4. start re-asserted with pattern=3'b111 mid-stream of test 1
//      -> ignored; the original 101101 stream completes unchanged.
//   5. rst=0 during the 2nd bit of a transfer
//      -> outputs 0 immediately (async, before the next edge); no done; next start works normally.
//   6. Loopback into the 101 detector: pattern=101, repeat_n=3, gap_en=0
//      -> detector output asserts 3 times (overlapping matches included per detector spec);
//         the generator's valid-bit count = 9.

Source files
------------

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB first,
// repeat_n times, with an optional one-cycle idle gap between repeats.
module moore_seq_gen #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             gap_en,
  output logic             data_out,
  output logic             valid_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat_q, pat_nx;
  logic [PAT_W-1:0] sreg, sreg_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic [CNT_W-1:0] rep_cnt, rep_nx;
  logic             gap_q, gap_nx;
  logic             data_nx, valid_nx, busy_nx, done_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      gap_q     <= 1'b0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pat_q     <= pat_nx;
      sreg      <= sreg_nx;
      bit_cnt   <= bit_nx;
      rep_cnt   <= rep_nx;
      gap_q     <= gap_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Outputs are computed for the next state and registered, so every output
  // reflects the state it is emitted in.
  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    sreg_nx  = sreg;
    bit_nx   = bit_cnt;
    rep_nx   = rep_cnt;
    gap_nx   = gap_q;
    data_nx  = 1'b0;
    valid_nx = 1'b0;
    busy_nx  = 1'b1;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          pat_nx  = pattern;
          sreg_nx = pattern;
          rep_nx  = repeat_n;
          gap_nx  = gap_en;
          bit_nx  = '0;
          busy_nx = 1'b1;
          if (repeat_n != '0) begin
            state_nx = SHIFT;
            data_nx  = pattern[PAT_W-1];
            valid_nx = 1'b1;
          end else begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
          // rep_cnt >= 1 whenever SHIFT is entered, so this cannot underflow
          rep_nx = rep_cnt - 1'b1;
          if (rep_cnt == CNT_W'(1)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else if (gap_q) begin
            state_nx = GAP;
          end else begin
            sreg_nx  = pat_q;
            bit_nx   = '0;
            data_nx  = pat_q[PAT_W-1];
            valid_nx = 1'b1;
          end
        end else begin
          sreg_nx  = {sreg[PAT_W-2:0], 1'b0};
          bit_nx   = bit_cnt + 1'b1;
          data_nx  = sreg[PAT_W-2];
          valid_nx = 1'b1;
        end
      end
      GAP: begin
        state_nx = SHIFT;
        sreg_nx  = pat_q;
        bit_nx   = '0;
        data_nx  = pat_q[PAT_W-1];
        valid_nx = 1'b1;
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen: expected per-cycle outputs are queued when a
// transfer is launched and popped against the DUT each cycle.
module tb_moore_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] pattern = '0;
  logic [3:0] repeat_n = '0;
  logic       gap_en = 1'b0;
  logic       data_out, valid_out, busy, done;

  int ncmp = 0;
  int nfail = 0;
  int vcnt = 0;
  int det = 0;
  logic [2:0] hist = '0;
  logic [3:0] q[$];

  moore_seq_gen #(.PAT_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .repeat_n(repeat_n), .gap_en(gap_en), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed={d,v,done,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected cycles {data_out, valid_out, done, busy} for one transfer.
  task automatic push_xfer(input logic [2:0] p, input int reps, input logic g);
    for (int r = 1; r <= reps; r++) begin
      for (int i = 2; i >= 0; i--) q.push_back({p[i], 1'b1, 1'b0, 1'b1});
      if (r < reps && g) q.push_back(4'b0001);
    end
    q.push_back(4'b0011);
    q.push_back(4'b0000);
  endtask

  task automatic launch(input logic [2:0] p, input int reps, input logic g, input logic hold);
    @(negedge clk);
    pattern = p; repeat_n = 4'(reps); gap_en = g; start = 1'b1;
    push_xfer(p, reps, g);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Pops one expectation per cycle; optional mid-stream start poke and start release.
  task automatic check_stream(input string tag, input int poke_at, input int drop_at);
    int idx = 0;
    logic [3:0] e;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      check(tag, {data_out, valid_out, done, busy}, e);
      if (valid_out) begin
        vcnt++;
        hist = {hist[1:0], data_out};
        if (hist == 3'b101) det++;
      end
      if (idx == poke_at) begin
        start = 1'b1; pattern = 3'b111; repeat_n = 4'd7; gap_en = 1'b1;
      end
      if (idx == drop_at) start = 1'b0;
      idx++;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 check("reset_state", {data_out, valid_out, done, busy}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1: 101 x2, no gap
    launch(3'b101, 2, 1'b0, 1'b0);
    check_stream("t1_101x2", -1, -1);

    // 2: 101 x2 with gap
    launch(3'b101, 2, 1'b1, 1'b0);
    check_stream("t2_gap", -1, -1);

    // 3: zero repeats
    launch(3'b101, 0, 1'b0, 1'b0);
    check_stream("t3_rep0", -1, -1);

    // 4: start/inputs changed mid-stream are ignored
    launch(3'b101, 2, 1'b0, 1'b0);
    check_stream("t4_ignore", 1, 4);

    // start held high: back-to-back transfers with one IDLE cycle between
    launch(3'b110, 1, 1'b0, 1'b1);
    push_xfer(3'b110, 1, 1'b0);
    check_stream("hold_start", -1, 5);

    // 5: async reset during the 2nd bit
    @(negedge clk);
    pattern = 3'b110; repeat_n = 4'd2; gap_en = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("t5_bit2", {data_out, valid_out, done, busy}, 4'b1101);
    #2 rst = 1'b0;
    #1 check("t5_async", {data_out, valid_out, done, busy}, 4'b0000);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_nodone", {data_out, valid_out, done, busy}, 4'b0000);
    end
    launch(3'b011, 1, 1'b1, 1'b0);
    check_stream("t5_restart", -1, -1);

    // 6: loopback into a 101 detector model
    vcnt = 0; det = 0; hist = '0;
    launch(3'b101, 3, 1'b0, 1'b0);
    check_stream("t6_stream", -1, -1);
    check("t6_det", 4'(det), 4'd3);
    check("t6_vcnt", 4'(vcnt), 4'd9);

    // max repeat count with gaps
    launch(3'b100, 15, 1'b1, 1'b0);
    check_stream("max_rep", -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
